// File: rtl/ka_partial_gen_8bit_pkg.sv
// Shared types and constants for the 8-bit carry-less Karatsuba multiplier.
// The overlap stage and later stages import this package as well.
package ka_pkg;
    localparam int KA_N = 8;
    localparam int KA_H = 4;
    localparam int KA_P = 2 * KA_H - 1;

    typedef enum logic [2:0] {
        IDLE,
        MUL_LO,
        MUL_HI,
        MUL_MID,
        DONE
    } ka_pg_state_t;
endpackage

// File: rtl/ka_partial_gen_8bit_if.sv
// Operand and partial-product handshake bundle of the Karatsuba front end.
// The master side is the upstream/downstream environment; the slave side is the block itself.
interface ka_partial_gen_8bit_if;
    logic                     in_valid;
    logic                     in_ready;
    logic [ka_pkg::KA_N-1:0]  a;
    logic [ka_pkg::KA_N-1:0]  b;
    logic                     out_valid;
    logic                     out_ready;
    logic [ka_pkg::KA_P-1:0]  p_lo;
    logic [ka_pkg::KA_P-1:0]  p_mid;
    logic [ka_pkg::KA_P-1:0]  p_hi;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p_lo, p_mid, p_hi
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p_lo, p_mid, p_hi
    );
endinterface

// File: rtl/ka_partial_gen_8bit_clmul_4bit.sv
// Combinational 4x4 carry-less multiply: p[k] is the XOR of x[i]&y[j] over i+j=k.
module clmul_4bit
    import ka_pkg::*;
(
    input  logic [KA_H-1:0] x,
    input  logic [KA_H-1:0] y,
    output logic [KA_P-1:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < KA_H; i++) begin
            for (int j = 0; j < KA_H; j++) begin
                p[i+j] = p[i+j] ^ (x[i] & y[j]);
            end
        end
    end
endmodule

// File: rtl/ka_partial_gen_8bit.sv
// Karatsuba front end: one shared 4x4 carry-less multiplier produces the low,
// high and corrected middle partial products over three cycles.
//
// state   | meaning
// IDLE    | in_ready high, waiting for an operand pair
// MUL_LO  | aL*bL into the low scratch register
// MUL_HI  | aH*bH into the high scratch register
// MUL_MID | middle product corrected and all three outputs committed
// DONE    | result presented, held until out_ready
module ka_partial_gen_8bit
    import ka_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    ka_partial_gen_8bit_if.slave  bus
);
    ka_pg_state_t    state;
    ka_pg_state_t    state_nxt;
    logic [KA_N-1:0] a_r;
    logic [KA_N-1:0] b_r;
    logic [KA_P-1:0] lo_r;
    logic [KA_P-1:0] hi_r;
    logic [KA_P-1:0] p_lo_r;
    logic [KA_P-1:0] p_mid_r;
    logic [KA_P-1:0] p_hi_r;
    logic            out_valid_r;
    logic [KA_H-1:0] mul_x;
    logic [KA_H-1:0] mul_y;
    logic [KA_P-1:0] mul_p;
    logic            accept;
    logic            ready;

    clmul_4bit u_clmul (
        .x (mul_x),
        .y (mul_y),
        .p (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = MUL_LO;
            MUL_LO:  state_nxt = MUL_HI;
            MUL_HI:  state_nxt = MUL_MID;
            MUL_MID: state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rst_n gates in_ready so the upstream never sees a ready while reset is held
    always_comb begin
        ready  = 1'b0;
        mul_x  = '0;
        mul_y  = '0;
        case (state)
            IDLE:    ready = rst_n;
            MUL_LO:  begin
                mul_x = a_r[KA_H-1:0];
                mul_y = b_r[KA_H-1:0];
            end
            MUL_HI:  begin
                mul_x = a_r[KA_N-1:KA_H];
                mul_y = b_r[KA_N-1:KA_H];
            end
            MUL_MID: begin
                mul_x = a_r[KA_H-1:0] ^ a_r[KA_N-1:KA_H];
                mul_y = b_r[KA_H-1:0] ^ b_r[KA_N-1:KA_H];
            end
            default: ;
        endcase
    end

    assign accept = ready & bus.in_valid;

    // lo/hi live in scratch registers so the outputs keep the previous result until MUL_MID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            b_r         <= '0;
            lo_r        <= '0;
            hi_r        <= '0;
            p_lo_r      <= '0;
            p_mid_r     <= '0;
            p_hi_r      <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept) begin
                a_r <= bus.a;
                b_r <= bus.b;
            end
            case (state)
                MUL_LO:  lo_r <= mul_p;
                MUL_HI:  hi_r <= mul_p;
                MUL_MID: begin
                    p_lo_r      <= lo_r;
                    p_hi_r      <= hi_r;
                    p_mid_r     <= mul_p ^ lo_r ^ hi_r;
                    out_valid_r <= 1'b1;
                end
                DONE:    if (bus.out_ready) out_valid_r <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_r;
    assign bus.p_lo      = p_lo_r;
    assign bus.p_mid     = p_mid_r;
    assign bus.p_hi      = p_hi_r;
endmodule
